// File: rtl/exc_entry_ctrl_pkg.sv
// Shared types, encodings and helpers for the exception entry sequencer.
// Mode codes drive the CPSR block's Change_M input; CPSR source codes drive W_CPSR_s.
package exc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAVE,
    S_MODE,
    S_BRANCH,
    S_RESTORE
  } state_e;

  typedef enum logic [1:0] {
    CLS_FIQ,
    CLS_IRQ,
    CLS_UND,
    CLS_SWI
  } cls_e;

  localparam logic [2:0] M_CUR = 3'd0;
  localparam logic [2:0] M_FIQ = 3'd1;
  localparam logic [2:0] M_IRQ = 3'd2;
  localparam logic [2:0] M_SVC = 3'd3;
  localparam logic [2:0] M_UND = 3'd4;

  localparam logic [2:0] CS_SPSR = 3'd0;
  localparam logic [2:0] CS_IRQ  = 3'd2;
  localparam logic [2:0] CS_FIQ  = 3'd3;
  localparam logic [2:0] CS_SVC  = 3'd4;
  localparam logic [2:0] CS_UND  = 3'd5;

  localparam logic [31:0] VOFS_UND = 32'h04;
  localparam logic [31:0] VOFS_SWI = 32'h08;
  localparam logic [31:0] VOFS_IRQ = 32'h18;
  localparam logic [31:0] VOFS_FIQ = 32'h1C;

  function automatic logic [2:0] mode(input cls_e c);
    case (c)
      CLS_FIQ: mode = M_FIQ;
      CLS_IRQ: mode = M_IRQ;
      CLS_UND: mode = M_UND;
      default: mode = M_SVC;
    endcase
  endfunction

  function automatic logic [2:0] code(input cls_e c);
    case (c)
      CLS_FIQ: code = CS_FIQ;
      CLS_IRQ: code = CS_IRQ;
      CLS_UND: code = CS_UND;
      default: code = CS_SVC;
    endcase
  endfunction

  function automatic logic [31:0] vec_ofs(input cls_e c);
    case (c)
      CLS_FIQ: vec_ofs = VOFS_FIQ;
      CLS_IRQ: vec_ofs = VOFS_IRQ;
      CLS_UND: vec_ofs = VOFS_UND;
      default: vec_ofs = VOFS_SWI;
    endcase
  endfunction

endpackage

// File: rtl/exc_entry_ctrl_prio_enc.sv
// Combinational priority encoder over qualified exception requests.
// Order: FIQ > IRQ > UND > SWI; exception return is handled by the caller.
module exc_prio_enc
  import exc_pkg::*;
(
  input  logic fiq_ok_i,
  input  logic irq_ok_i,
  input  logic und_i,
  input  logic swi_i,
  output logic vld_o,
  output cls_e cls_o
);

  always_comb begin
    vld_o = 1'b1;
    cls_o = CLS_FIQ;
    if (fiq_ok_i)      cls_o = CLS_FIQ;
    else if (irq_ok_i) cls_o = CLS_IRQ;
    else if (und_i)    cls_o = CLS_UND;
    else if (swi_i)    cls_o = CLS_SWI;
    else               vld_o = 1'b0;
  end

endmodule

// File: rtl/exc_entry_ctrl.sv
// Exception entry/return sequencer driving the CPSR/SPSR block: SAVE -> MODE -> BRANCH, or RESTORE.
// Optional EXC_IRQ_EDGE_LATCH_EN: irq/fiq rising edges set sticky pending bits used instead of levels.
module exc_entry_ctrl
  import exc_pkg::*;
#(
  parameter logic [31:0] VEC_BASE   = 32'h0000_0000,
  parameter logic [31:0] FIQ_LR_OFS = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        irq,
  input  logic        fiq,
  input  logic        und_req,
  input  logic        swi_req,
  input  logic        eret_req,
  input  logic        inst_boundary,
  input  logic [1:0]  cpsr_if,
  input  logic [31:0] pc_next,
  output logic        stall,
  output logic [2:0]  Change_M,
  output logic        W_SPSR_s,
  output logic        Write_SPSR,
  output logic [2:0]  W_CPSR_s,
  output logic        Write_CPSR,
  output logic        lr_we,
  output logic [31:0] lr_data,
  output logic        pc_we,
  output logic [31:0] pc_data
);

  state_e      state_q;
  cls_e        cls_q;
  logic [31:0] lr_q;
  logic [31:0] vec_q;

  logic irq_src, fiq_src;
  logic enc_vld;
  cls_e enc_cls;

`ifdef EXC_IRQ_EDGE_LATCH_EN
  logic irq_prev_q, fiq_prev_q;
  logic irq_pend_q, fiq_pend_q;
  logic irq_pend_d, fiq_pend_d;

  // A new edge in the clearing SAVE cycle must survive, so the set term is ORed last.
  always_comb begin
    irq_pend_d = (irq_pend_q & ~(state_q == S_SAVE && cls_q == CLS_IRQ)) | (irq & ~irq_prev_q);
    fiq_pend_d = (fiq_pend_q & ~(state_q == S_SAVE && cls_q == CLS_FIQ)) | (fiq & ~fiq_prev_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_prev_q <= 1'b0;
      fiq_prev_q <= 1'b0;
      irq_pend_q <= 1'b0;
      fiq_pend_q <= 1'b0;
    end else begin
      irq_prev_q <= irq;
      fiq_prev_q <= fiq;
      irq_pend_q <= irq_pend_d;
      fiq_pend_q <= fiq_pend_d;
    end
  end

  assign irq_src = irq_pend_q;
  assign fiq_src = fiq_pend_q;
`else
  assign irq_src = irq;
  assign fiq_src = fiq;
`endif

  exc_prio_enc u_prio (
    .fiq_ok_i (fiq_src & ~cpsr_if[0]),
    .irq_ok_i (irq_src & ~cpsr_if[1]),
    .und_i    (und_req),
    .swi_i    (swi_req),
    .vld_o    (enc_vld),
    .cls_o    (enc_cls)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cls_q   <= CLS_FIQ;
      lr_q    <= 32'd0;
      vec_q   <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (inst_boundary) begin
            if (enc_vld) begin
              cls_q   <= enc_cls;
              lr_q    <= (enc_cls == CLS_FIQ || enc_cls == CLS_IRQ) ? pc_next + FIQ_LR_OFS : pc_next;
              vec_q   <= VEC_BASE + vec_ofs(enc_cls);
              state_q <= S_SAVE;
            end else if (eret_req) begin
              state_q <= S_RESTORE;
            end
          end
        end
        S_SAVE:   state_q <= S_MODE;
        S_MODE:   state_q <= S_BRANCH;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    stall      = 1'b0;
    Change_M   = M_CUR;
    W_SPSR_s   = 1'b0;
    Write_SPSR = 1'b0;
    W_CPSR_s   = CS_SPSR;
    Write_CPSR = 1'b0;
    lr_we      = 1'b0;
    lr_data    = 32'd0;
    pc_we      = 1'b0;
    pc_data    = 32'd0;
    case (state_q)
      S_SAVE: begin
        stall      = 1'b1;
        Change_M   = mode(cls_q);
        W_SPSR_s   = 1'b1;
        Write_SPSR = 1'b1;
        lr_data    = lr_q;
        pc_data    = vec_q;
      end
      S_MODE: begin
        stall      = 1'b1;
        Change_M   = mode(cls_q);
        W_CPSR_s   = code(cls_q);
        Write_CPSR = 1'b1;
        lr_data    = lr_q;
        pc_data    = vec_q;
      end
      S_BRANCH: begin
        stall      = 1'b1;
        Change_M   = mode(cls_q);
        lr_we      = 1'b1;
        pc_we      = 1'b1;
        lr_data    = lr_q;
        pc_data    = vec_q;
      end
      S_RESTORE: begin
        stall      = 1'b1;
        Write_CPSR = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_exc_entry_ctrl.sv
// Bench for exc_entry_ctrl: directed scenarios then randomized traffic against a cycle-schedule model.
module tb_exc_entry_ctrl;

  localparam logic [31:0] VEC_BASE = 32'h0000_0000;
  localparam logic [31:0] LR_OFS   = 32'd4;

  logic        clk = 1'b0;
  logic        rst, irq, fiq, und_req, swi_req, eret_req, inst_boundary;
  logic [1:0]  cpsr_if;
  logic [31:0] pc_next;
  logic        stall, W_SPSR_s, Write_SPSR, Write_CPSR, lr_we, pc_we;
  logic [2:0]  Change_M, W_CPSR_s;
  logic [31:0] lr_data, pc_data;

  always #5 clk = ~clk;

  exc_entry_ctrl #(.VEC_BASE(VEC_BASE), .FIQ_LR_OFS(LR_OFS)) dut (
    .clk(clk), .rst(rst), .irq(irq), .fiq(fiq), .und_req(und_req), .swi_req(swi_req),
    .eret_req(eret_req), .inst_boundary(inst_boundary), .cpsr_if(cpsr_if), .pc_next(pc_next),
    .stall(stall), .Change_M(Change_M), .W_SPSR_s(W_SPSR_s), .Write_SPSR(Write_SPSR),
    .W_CPSR_s(W_CPSR_s), .Write_CPSR(Write_CPSR), .lr_we(lr_we), .lr_data(lr_data),
    .pc_we(pc_we), .pc_data(pc_data)
  );

  // Expected outputs for one cycle; save_cls marks the SAVE cycle of FIQ (1) or IRQ (2).
  typedef struct {
    logic        stall;
    logic [2:0]  cm;
    logic        wss, wsp;
    logic [2:0]  wcs;
    logic        wcp, lrwe, pcwe;
    logic [31:0] lr, pc;
    int          save_cls;
  } exp_t;

  exp_t q[$];
  bit   cur_idle = 1'b1;
  int   cur_save = 0;
  bit   pend_i = 0, pend_f = 0, prev_i = 0, prev_f = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t zero_exp();
    exp_t e;
    e.stall = 0; e.cm = 0; e.wss = 0; e.wsp = 0; e.wcs = 0; e.wcp = 0;
    e.lrwe = 0; e.pcwe = 0; e.lr = 0; e.pc = 0; e.save_cls = 0;
    return e;
  endfunction

  task automatic push_entry(input logic [2:0] cm, input logic [2:0] cs,
                            input logic [31:0] lr, input logic [31:0] pc, input int sc);
    exp_t e;
    e = zero_exp();
    e.stall = 1; e.cm = cm; e.lr = lr; e.pc = pc;
    e.wss = 1; e.wsp = 1; e.save_cls = sc;
    q.push_back(e);
    e.wss = 0; e.wsp = 0; e.save_cls = 0; e.wcs = cs; e.wcp = 1;
    q.push_back(e);
    e.wcs = 0; e.wcp = 0; e.lrwe = 1; e.pcwe = 1;
    q.push_back(e);
  endtask

  task automatic model_step();
    bit irq_lvl, fiq_lvl;
    if (rst) begin
      q.delete();
      pend_i = 0; pend_f = 0; prev_i = 0; prev_f = 0;
    end else begin
`ifdef EXC_IRQ_EDGE_LATCH_EN
      irq_lvl = pend_i;
      fiq_lvl = pend_f;
`else
      irq_lvl = irq;
      fiq_lvl = fiq;
`endif
      if (cur_idle && inst_boundary) begin
        if (fiq_lvl && !cpsr_if[0])      push_entry(3'd1, 3'd3, pc_next + LR_OFS, VEC_BASE + 32'h1C, 1);
        else if (irq_lvl && !cpsr_if[1]) push_entry(3'd2, 3'd2, pc_next + LR_OFS, VEC_BASE + 32'h18, 2);
        else if (und_req)                push_entry(3'd4, 3'd5, pc_next, VEC_BASE + 32'h04, 0);
        else if (swi_req)                push_entry(3'd3, 3'd4, pc_next, VEC_BASE + 32'h08, 0);
        else if (eret_req) begin
          exp_t e;
          e = zero_exp();
          e.stall = 1; e.wcp = 1;
          q.push_back(e);
        end
      end
      pend_i = (pend_i && cur_save != 2) || (irq && !prev_i);
      pend_f = (pend_f && cur_save != 1) || (fiq && !prev_f);
      prev_i = irq;
      prev_f = fiq;
    end
  endtask

  task automatic step();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      cur_idle = 0;
    end else begin
      e = zero_exp();
      cur_idle = 1;
    end
    cur_save = e.save_cls;
    check_val("stall", {31'd0, stall}, {31'd0, e.stall});
    check_val("Change_M", {29'd0, Change_M}, {29'd0, e.cm});
    check_val("W_SPSR_s", {31'd0, W_SPSR_s}, {31'd0, e.wss});
    check_val("Write_SPSR", {31'd0, Write_SPSR}, {31'd0, e.wsp});
    check_val("W_CPSR_s", {29'd0, W_CPSR_s}, {29'd0, e.wcs});
    check_val("Write_CPSR", {31'd0, Write_CPSR}, {31'd0, e.wcp});
    check_val("lr_we", {31'd0, lr_we}, {31'd0, e.lrwe});
    check_val("pc_we", {31'd0, pc_we}, {31'd0, e.pcwe});
    check_val("lr_data", lr_data, e.lr);
    check_val("pc_data", pc_data, e.pc);
  endtask

  task automatic quiet();
    rst = 0; irq = 0; fiq = 0; und_req = 0; swi_req = 0; eret_req = 0;
    inst_boundary = 0; cpsr_if = 2'b00; pc_next = 32'h0;
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) begin
      quiet();
      step();
    end
  endtask

  initial begin
    quiet();
    rst = 1;
    step();
    step();
    run_idle(2);

    // IRQ entry
    quiet(); irq = 1; inst_boundary = 1; pc_next = 32'h100;
    step();
    irq = 1; inst_boundary = 0;
    step();
    quiet();
    step(); step(); step();
    check_val("irq_seq_done", {31'd0, q.size() == 0}, 32'd1);

    // FIQ beats IRQ
    run_idle(1);
    quiet(); irq = 1; fiq = 1; inst_boundary = 1; pc_next = 32'h3000;
    step();
    quiet(); irq = 1; fiq = 1;
    step(); step(); step();
    run_idle(2);

    // Masked IRQ does nothing
    quiet(); irq = 1; cpsr_if = 2'b10; inst_boundary = 1;
    step(); step(); step();
    run_idle(1);

    // SWI
    quiet(); swi_req = 1; inst_boundary = 1; pc_next = 32'h200;
    step();
    quiet(); swi_req = 1;
    step(); step(); step();
    run_idle(1);

    // Exception return
    quiet(); eret_req = 1; inst_boundary = 1;
    step();
    quiet();
    step(); step();

    // Reset during MODE abandons the entry
    quiet(); und_req = 1; inst_boundary = 1; pc_next = 32'h440;
    step();
    step();
    rst = 1;
    step();
    quiet();
    step(); step();

    // Single irq pulse away from a boundary, then a boundary later
    quiet(); irq = 1;
    step();
    run_idle(3);
    quiet(); inst_boundary = 1; pc_next = 32'h800;
    step();
    quiet();
    step(); step(); step();
    quiet(); inst_boundary = 1;
    step(); step();
    run_idle(2);

    // LR wrap-around
    quiet(); irq = 1; inst_boundary = 1; pc_next = 32'hFFFF_FFFE;
    step();
    quiet(); irq = 1;
    step(); step(); step();
    run_idle(2);

    for (int i = 0; i < 800; i++) begin
      rst           = ($urandom % 50) == 0;
      irq           = ($urandom % 4) == 0;
      fiq           = ($urandom % 5) == 0;
      und_req       = ($urandom % 6) == 0;
      swi_req       = ($urandom % 6) == 0;
      eret_req      = ($urandom % 5) == 0;
      inst_boundary = ($urandom % 2) == 0;
      cpsr_if       = 2'($urandom % 4);
      pc_next       = (($urandom % 4) == 0) ? 32'hFFFF_FFFC + 32'($urandom % 4) : $urandom;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
